restador_serial_8b: RTL and testbench

RESTADOR_SERIAL_8B -- requirements
Module: restador_serial_8b

---
 rtl/restador_serial_8b.sv | 144 ++++++++++++++
 tb/tb_restador_serial_8b.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/restador_serial_8b.sv
// Bit-serial subtractor: a - b - entPrestamo, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining RESTADOR_OVERFLOW_EN.
module restador_serial_8b #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             entPrestamo,
    output logic             ocupado,
    output logic             listo,
    output logic [WIDTH-1:0] resta,
    output logic             salPrestamo
`ifdef RESTADOR_OVERFLOW_EN
    ,
    output logic             desbordamiento
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        INACTIVO,
        RESTANDO,
        LISTO
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             p_q, p_d;
    logic [WIDTH-1:0] dif_q, dif_d;
    logic [WIDTH-1:0] resta_q, resta_d;
    logic             salp_q, salp_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;
`ifdef RESTADOR_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, d_bit, p_next;

    // Current-bit full-subtractor cell.
    always_comb begin
        a_bit  = a_q[cnt_q];
        b_bit  = b_q[cnt_q];
        d_bit  = a_bit ^ b_bit ^ p_q;
        p_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & p_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INACTIVO;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= 1'b0;
            dif_q     <= '0;
            resta_q   <= '0;
            salp_q    <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
`ifdef RESTADOR_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            dif_q     <= dif_d;
            resta_q   <= resta_d;
            salp_q    <= salp_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
`ifdef RESTADOR_OVERFLOW_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        dif_d     = dif_q;
        resta_d   = resta_q;
        salp_d    = salp_q;
        ocupado_d = 1'b0;
        listo_d   = 1'b0;
`ifdef RESTADOR_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            INACTIVO, LISTO: begin
                if (iniciar) begin
                    a_d       = a;
                    b_d       = b;
                    p_d       = entPrestamo;
                    cnt_d     = '0;
                    dif_d     = '0;
                    ocupado_d = 1'b1;
                    state_d   = RESTANDO;
                end else begin
                    state_d = INACTIVO;
                end
            end
            RESTANDO: begin
                // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                dif_d     = {d_bit, dif_q[WIDTH-1:1]};
                p_d       = p_next;
                cnt_d     = cnt_q + CW'(1);
                ocupado_d = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d     = '0;
                    resta_d   = {d_bit, dif_q[WIDTH-1:1]};
                    salp_d    = p_next;
                    ocupado_d = 1'b0;
                    listo_d   = 1'b1;
                    state_d   = LISTO;
`ifdef RESTADOR_OVERFLOW_EN
                    ovf_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = INACTIVO;
        endcase
    end

    assign ocupado     = ocupado_q;
    assign listo       = listo_q;
    assign resta       = resta_q;
    assign salPrestamo = salp_q;
`ifdef RESTADOR_OVERFLOW_EN
    assign desbordamiento = ovf_q;
`endif

endmodule

// File: tb/tb_restador_serial_8b.sv
// Directed self-checking bench for restador_serial_8b (WIDTH=8).
module tb_restador_serial_8b;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         iniciar;
    logic [W-1:0] a, b;
    logic         entPrestamo;
    logic         ocupado, listo, salPrestamo;
    logic [W-1:0] resta;
`ifdef RESTADOR_OVERFLOW_EN
    logic         desbordamiento;
`endif

    int checks = 0;
    int errors = 0;

    restador_serial_8b #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .iniciar(iniciar),
        .a(a),
        .b(b),
        .entPrestamo(entPrestamo),
        .ocupado(ocupado),
        .listo(listo),
        .resta(resta),
        .salPrestamo(salPrestamo)
`ifdef RESTADOR_OVERFLOW_EN
        ,
        .desbordamiento(desbordamiento)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, then check busy, hold, completion and return to idle.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vp, input logic [W-1:0] er, input logic eb);
        logic [W-1:0] prev;
        prev        = resta;
        a           = va;
        b           = vb;
        entPrestamo = vp;
        iniciar     = 1'b1;
        tick(1);
        iniciar = 1'b0;
        a       = ~va;
        b       = ~vb;
        chk({tag, "_busy"}, 32'(ocupado), 32'd1);
        tick(W - 1);
        chk({tag, "_nolisto"}, 32'(listo), 32'd0);
        chk({tag, "_hold"}, 32'(resta), 32'(prev));
        tick(1);
        chk({tag, "_listo"}, 32'(listo), 32'd1);
        chk({tag, "_resta"}, 32'(resta), 32'(er));
        chk({tag, "_borrow"}, 32'(salPrestamo), 32'(eb));
        chk({tag, "_idlebusy"}, 32'(ocupado), 32'd0);
        tick(1);
        chk({tag, "_pulse1"}, 32'(listo), 32'd0);
        chk({tag, "_keep"}, 32'(resta), 32'(er));
    endtask

    initial begin
        rst = 1'b1; iniciar = 1'b0; a = '0; b = '0; entPrestamo = 1'b0;
        tick(2);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_resta", 32'(resta), 32'd0);
        chk("rst_borrow", 32'(salPrestamo), 32'd0);
        rst = 1'b0;
        tick(1);

        run_op("t31", 8'd5, 8'd5, 1'b1, 8'hFF, 1'b1);

        // Back-to-back with iniciar held high.
        a = 8'd4; b = 8'd7; entPrestamo = 1'b0; iniciar = 1'b1;
        tick(1);
        a = 8'd8; b = 8'd6;
        tick(W);
        chk("t32a_listo", 32'(listo), 32'd1);
        chk("t32a_resta", 32'(resta), 32'hFD);
        chk("t32a_borrow", 32'(salPrestamo), 32'd1);
        tick(1);
        chk("t32b_busy", 32'(ocupado), 32'd1);
        chk("t32b_listo0", 32'(listo), 32'd0);
        a = 8'd1; b = 8'd1;
        tick(W - 1);
        chk("t32b_hold", 32'(resta), 32'hFD);
        tick(1);
        iniciar = 1'b0;
        chk("t32b_listo", 32'(listo), 32'd1);
        chk("t32b_resta", 32'(resta), 32'h02);
        chk("t32b_borrow", 32'(salPrestamo), 32'd0);
        tick(1);
        chk("t32_idle", 32'(ocupado), 32'd0);

        // Start request during RESTANDO is ignored.
        a = 8'd11; b = 8'd5; entPrestamo = 1'b1; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0; a = 8'd2; b = 8'd9; entPrestamo = 1'b0;
        tick(2);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(4);
        chk("t33_busy", 32'(ocupado), 32'd1);
        chk("t33_nolisto", 32'(listo), 32'd0);
        tick(1);
        chk("t33_listo", 32'(listo), 32'd1);
        chk("t33_resta", 32'(resta), 32'h05);
        chk("t33_borrow", 32'(salPrestamo), 32'd0);
        tick(1);
        chk("t33_idle", 32'(ocupado), 32'd0);
        chk("t33_listo0", 32'(listo), 32'd0);

        // Reset aborts in the 4th RESTANDO cycle.
        a = 8'hFF; b = 8'hFF; entPrestamo = 1'b0; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t34_ocupado", 32'(ocupado), 32'd0);
        chk("t34_listo", 32'(listo), 32'd0);
        chk("t34_resta", 32'(resta), 32'd0);
        chk("t34_borrow", 32'(salPrestamo), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t34_nopulse", 32'({listo, ocupado}), 32'd0);
        end

        // Reset wins over iniciar; first edge after release accepts.
        rst = 1'b1; iniciar = 1'b1; a = 8'd9; b = 8'd3; entPrestamo = 1'b0;
        tick(1);
        chk("t28_rstwin", 32'(ocupado), 32'd0);
        rst = 1'b0;
        tick(1);
        iniciar = 1'b0;
        chk("t28_accept", 32'(ocupado), 32'd1);
        tick(W);
        chk("t28_listo", 32'(listo), 32'd1);
        chk("t28_resta", 32'(resta), 32'h06);
        tick(1);

        run_op("b00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op("b0f", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        run_op("bf0", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_op("bab", 8'hA5, 8'h3C, 1'b0, 8'h69, 1'b0);

`ifdef RESTADOR_OVERFLOW_EN
        run_op("ov1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        chk("ov1_flag", 32'(desbordamiento), 32'd1);
        run_op("ov0", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        chk("ov0_flag", 32'(desbordamiento), 32'd0);
        run_op("ov2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
        chk("ov2_flag", 32'(desbordamiento), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
